ahb_arbiter: RTL and testbench

- Round-robin AHB bus arbiter for up to NUM_MASTERS bus masters sharing one AHB address/data bus, for example the CAN transmitter master plus test-bench masters.
- Samples the per-master bus requests and drives one-hot grants.
- Tracks the address-phase owner and the data-phase owner, which steer the bus muxes in the test bench.
- Never hands the bus over in the middle of a fixed-length burst.

---
 rtl/ahb_pkg.sv | 34 +++
 rtl/ahb_arbiter_if.sv | 24 ++
 rtl/ahb_rr_pick.sv | 25 ++
 rtl/ahb_arbiter.sv | 90 +++++++++
 tb/tb_ahb_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and burst-length helper for the round-robin arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  localparam int MIDX_W = 4;

  // Beats still owed after the NONSEQ of a burst; undefined-length bursts owe none.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    case (hburst_e'(hburst))
      SINGLE, INCR:   return 4'd0;
      WRAP4,  INCR4:  return 4'd3;
      WRAP8,  INCR8:  return 4'd7;
      default:        return 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);

  logic [NUM_MASTERS-1:0]     HBUSREQ;
  logic [1:0]                 HTRANS;
  logic [2:0]                 HBURST;
  logic                       HREADY;
  logic [NUM_MASTERS-1:0]     HGRANT;
  logic [ahb_pkg::MIDX_W-1:0] HMASTER;
  logic [ahb_pkg::MIDX_W-1:0] HMASTER_D;

  modport master (
    output HBUSREQ, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTER_D
  );

  modport slave (
    input  HBUSREQ, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTER_D
  );

endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping around.
module ahb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [3:0]   ptr_i,
  output logic [3:0]   winner_o,
  output logic         valid_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Walk offsets from farthest to nearest so the nearest requester after ptr is written last.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int off = N; off >= 1; off--) begin
      if (req_i[IW'((int'(ptr_i) + off) % N)]) begin
        winner_o = 4'((int'(ptr_i) + off) % N);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst protection and address/data-phase owner tracking.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DEF_MASTER  = 0
) (
  input logic          HCLK,
  input logic          HRESET,
  ahb_arbiter_if.slave bus
);

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEF_MASTER;
  localparam logic [3:0]             DEF_IDX   = 4'(DEF_MASTER);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [3:0]             owner_q, owner_d;
  logic [3:0]             data_owner_q, data_owner_d;
  logic [3:0]             beats_q, beats_d;
  logic [3:0]             rr_ptr_q, rr_ptr_d;

  logic       arb_en;
  logic [3:0] grant_idx;
  logic [3:0] pick_winner;
  logic       pick_valid;

  ahb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i   (bus.HBUSREQ),
    .ptr_i   (rr_ptr_q),
    .winner_o(pick_winner),
    .valid_o (pick_valid)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) grant_idx = 4'(i);
    end
  end

  // Re-arbitrate only between bursts or while the final beat of a burst is accepted.
  assign arb_en = bus.HREADY &&
                  ((beats_q == 4'd0) || ((beats_q == 4'd1) && (bus.HTRANS == SEQ)));

  always_comb begin
    grant_d      = grant_q;
    owner_d      = owner_q;
    data_owner_d = data_owner_q;
    beats_d      = beats_q;
    rr_ptr_d     = rr_ptr_q;
    if (bus.HREADY) begin
      data_owner_d = owner_q;
      owner_d      = grant_idx;
      case (htrans_e'(bus.HTRANS))
        NONSEQ:  beats_d = burst_beats(bus.HBURST);
        SEQ:     if (beats_q != 4'd0) beats_d = beats_q - 4'd1;
        default: beats_d = beats_q;
      endcase
    end
    if (arb_en) begin
      if (pick_valid) begin
        grant_d  = NUM_MASTERS'(1) << pick_winner;
        rr_ptr_d = pick_winner;
      end else begin
        grant_d = DEF_GRANT;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      grant_q      <= DEF_GRANT;
      owner_q      <= DEF_IDX;
      data_owner_q <= DEF_IDX;
      beats_q      <= '0;
      rr_ptr_q     <= DEF_IDX;
    end else begin
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      data_owner_q <= data_owner_d;
      beats_q      <= beats_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = owner_q;
  assign bus.HMASTER_D = data_owner_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus randomized run against a reference model.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic HCLK = 1'b0;
  logic HRESET;
  int   compared = 0;
  int   failed   = 0;

  // Reference model state, as plain master indices and counts.
  int m_grant, m_owner, m_downer, m_beats, m_ptr;

  ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_arbiter #(.NUM_MASTERS(N), .DEF_MASTER(DEF)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic model_step();
    bit arb;
    int b;
    int req;
    arb = 1'b0;
    b   = int'(bus.HBURST);
    req = int'(bus.HBUSREQ);
    if (!HRESET) begin
      m_grant = DEF; m_owner = DEF; m_downer = DEF; m_beats = 0; m_ptr = DEF;
    end else if (bus.HREADY) begin
      arb = (m_beats == 0) || (m_beats == 1 && bus.HTRANS == 2'd3);
      m_downer = m_owner;
      m_owner  = m_grant;
      if (bus.HTRANS == 2'd2) m_beats = (b < 2) ? 0 : ((1 << ((b >> 1) + 1)) - 1);
      else if (bus.HTRANS == 2'd3 && m_beats > 0) m_beats = m_beats - 1;
      if (arb) begin
        if (req == 0) m_grant = DEF;
        else begin
          for (int k = 1; k <= N; k++) begin
            if (req[(m_ptr + k) % N]) begin
              m_grant = (m_ptr + k) % N;
              m_ptr   = m_grant;
              break;
            end
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic [3:0] req, input logic [1:0] trans,
                               input logic [2:0] burst, input logic ready);
    HRESET      = rst_n;
    bus.HBUSREQ = req;
    bus.HTRANS  = trans;
    bus.HBURST  = burst;
    bus.HREADY  = ready;
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic       rst[3]   = '{1'b0, 1'b0, 1'b1};
    logic [3:0] exp_g[3] = '{4'b0001, 4'b0001, 4'b0010};
    for (int s = 0; s < 3; s++) begin
      applyStimulus(rst[s], 4'b1111, NONSEQ, SINGLE, 1'b1);
      compared++;
      if (bus.HGRANT !== exp_g[s]) begin
        failed++; $display("[TB] FAIL reset_grant step %0d: got %b want %b", s, bus.HGRANT, exp_g[s]);
      end
      compared++;
      if (bus.HMASTER !== 4'd0 || bus.HMASTER_D !== 4'd0) begin
        failed++; $display("[TB] FAIL reset_owner step %0d: got %0d/%0d want 0/0", s, bus.HMASTER, bus.HMASTER_D);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g[4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] exp_o[4] = '{4'd1, 4'd2, 4'd3, 4'd0};
    logic [3:0] exp_d[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 4'b1111, NONSEQ, SINGLE, 1'b1);
      compared++;
      if (bus.HGRANT !== exp_g[s] || bus.HMASTER !== exp_o[s] || bus.HMASTER_D !== exp_d[s]) begin
        failed++;
        $display("[TB] FAIL round_robin step %0d: got %b/%0d/%0d want %b/%0d/%0d",
                 s, bus.HGRANT, bus.HMASTER, bus.HMASTER_D, exp_g[s], exp_o[s], exp_d[s]);
      end
    end
  endtask

  task automatic test_burst_protect();
    logic [3:0] req[6]   = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0101, 4'b0101};
    logic [1:0] tr[6]    = '{IDLE, IDLE, NONSEQ, SEQ, SEQ, SEQ};
    logic [3:0] exp_g[6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    logic [3:0] exp_b[6] = '{4'd0, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    for (int s = 0; s < 6; s++) begin
      applyStimulus(1'b1, req[s], tr[s], INCR4, 1'b1);
      compared++;
      if (bus.HGRANT !== exp_g[s] || dut.beats_q !== exp_b[s]) begin
        failed++;
        $display("[TB] FAIL burst_protect step %0d: grant/beats got %b/%0d want %b/%0d",
                 s, bus.HGRANT, dut.beats_q, exp_g[s], exp_b[s]);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [3:0] req[10]   = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0101,
                              4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
    logic [1:0] tr[10]    = '{IDLE, IDLE, NONSEQ, SEQ, SEQ, SEQ, SEQ, BUSY, SEQ, SEQ};
    logic       rdy[10]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_g[10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                              4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    logic [3:0] exp_o[10] = '{4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [3:0] exp_d[10] = '{4'd2, 4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [3:0] exp_b[10] = '{4'd0, 4'd0, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
    for (int s = 0; s < 10; s++) begin
      applyStimulus(1'b1, req[s], tr[s], INCR4, rdy[s]);
      compared++;
      if (bus.HGRANT !== exp_g[s] || bus.HMASTER !== exp_o[s] ||
          bus.HMASTER_D !== exp_d[s] || dut.beats_q !== exp_b[s]) begin
        failed++;
        $display("[TB] FAIL wait_states step %0d: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", s,
                 bus.HGRANT, bus.HMASTER, bus.HMASTER_D, dut.beats_q,
                 exp_g[s], exp_o[s], exp_d[s], exp_b[s]);
      end
    end
  endtask

  task automatic test_parking();
    logic [3:0] req[4]   = '{4'b1000, 4'b1000, 4'b0000, 4'b0011};
    logic [3:0] exp_g[4] = '{4'b1000, 4'b1000, 4'b0001, 4'b0001};
    logic [3:0] exp_p[4] = '{4'd3, 4'd3, 4'd3, 4'd0};
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, req[s], IDLE, SINGLE, 1'b1);
      compared++;
      if (bus.HGRANT !== exp_g[s] || dut.rr_ptr_q !== exp_p[s]) begin
        failed++;
        $display("[TB] FAIL parking step %0d: grant/ptr got %b/%0d want %b/%0d",
                 s, bus.HGRANT, dut.rr_ptr_q, exp_g[s], exp_p[s]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic       rst[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] tr[6]    = '{IDLE, IDLE, NONSEQ, SEQ, SEQ, IDLE};
    logic [3:0] exp_g[6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] exp_b[6] = '{4'd0, 4'd0, 4'd7, 4'd6, 4'd0, 4'd0};
    logic [3:0] exp_p[6] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
    for (int s = 0; s < 6; s++) begin
      applyStimulus(rst[s], 4'b0010, tr[s], INCR8, 1'b1);
      compared++;
      if (bus.HGRANT !== exp_g[s] || dut.beats_q !== exp_b[s] || dut.rr_ptr_q !== exp_p[s]) begin
        failed++;
        $display("[TB] FAIL reset_mid_burst step %0d: grant/beats/ptr got %b/%0d/%0d want %b/%0d/%0d",
                 s, bus.HGRANT, dut.beats_q, dut.rr_ptr_q, exp_g[s], exp_b[s], exp_p[s]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_g;
    for (int s = 0; s < 400; s++) begin
      applyStimulus(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0));
      exp_g = 4'(1 << m_grant);
      compared++;
      if (bus.HGRANT !== exp_g || !$onehot(bus.HGRANT)) begin
        failed++; $display("[TB] FAIL random_grant cycle %0d: got %b want %b", s, bus.HGRANT, exp_g);
      end
      compared++;
      if (bus.HMASTER !== 4'(m_owner) || bus.HMASTER_D !== 4'(m_downer)) begin
        failed++;
        $display("[TB] FAIL random_owner cycle %0d: got %0d/%0d want %0d/%0d",
                 s, bus.HMASTER, bus.HMASTER_D, m_owner, m_downer);
      end
      compared++;
      if (dut.rr_ptr_q !== 4'(m_ptr) || dut.beats_q !== 4'(m_beats)) begin
        failed++;
        $display("[TB] FAIL random_state cycle %0d: ptr/beats got %0d/%0d want %0d/%0d",
                 s, dut.rr_ptr_q, dut.beats_q, m_ptr, m_beats);
      end
    end
  endtask

  initial begin
    $display("[TB] starting ahb_arbiter bench");
    test_reset();
    test_round_robin();
    test_burst_protect();
    test_wait_states();
    test_parking();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
